// File: rtl/gpio_io_periph.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : gpio_io_periph                                         |
// | Brief    : per-bit button debouncer, 8N1 UART transmitter and     |
// |            two-LED RGB colour-wheel PWM driver                    |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module gpio_io_periph #(
    parameter int DEBNC_CLOCKS = 65536,
    parameter int PORT_WIDTH   = 4,
    parameter int BAUD_CLKS    = 10416,
    parameter int STEP_CLKS    = 100000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PORT_WIDTH-1:0] SIGNAL_I,
    output logic [PORT_WIDTH-1:0] SIGNAL_O,
    input  logic                  SEND,
    input  logic [7:0]            DATA,
    output logic                  READY,
    output logic                  UART_TX,
    output logic [2:0]            RGB_LED_1_O,
    output logic [2:0]            RGB_LED_2_O
);

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    localparam int c_DEB_W = (DEBNC_CLOCKS > 1) ? $clog2(DEBNC_CLOCKS) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBNC_CLOCKS - 1);

    logic [PORT_WIDTH-1:0] r_sync1;
    logic [PORT_WIDTH-1:0] r_sync2;
    logic [PORT_WIDTH-1:0] w_deb_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= SIGNAL_I;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PORT_WIDTH; gi++) begin : g_debounce
            logic [c_DEB_W-1:0] r_cnt;
            logic               r_level;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (r_sync2[gi] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    r_level <= r_sync2[gi];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_deb_out[gi] = r_level;
        end
    endgenerate

    assign SIGNAL_O = w_deb_out;

    // ------------------------------------------------------------------
    // UART transmitter (8N1)
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_RDY  = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;

    localparam int c_BAUD_W = (BAUD_CLKS > 2) ? $clog2(BAUD_CLKS) : 1;
    // The LOAD_BIT cycle is part of each bit period, so SEND_BIT ends one count
    // early; the stop bit has no following LOAD_BIT and runs the full count.
    localparam logic [c_BAUD_W-1:0] c_BIT_LAST  = c_BAUD_W'(BAUD_CLKS - 2);
    localparam logic [c_BAUD_W-1:0] c_STOP_LAST = c_BAUD_W'(BAUD_CLKS - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [9:0]          r_frame;
    logic [3:0]          r_bit_idx;
    logic [c_BAUD_W-1:0] r_timer;
    logic                r_tx;
    logic                r_ready;
    logic                w_tx_nxt;
    logic                w_ready_nxt;
    logic                w_last_bit;
    logic                w_bit_done;

    assign w_last_bit = (r_bit_idx == 4'd9);
    assign w_bit_done = (r_state == c_ST_SEND) &&
                        (r_timer == (w_last_bit ? c_STOP_LAST : c_BIT_LAST));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_RDY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RDY:  if (SEND) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD: w_state_nxt = c_ST_SEND;
            c_ST_SEND: if (w_bit_done) w_state_nxt = w_last_bit ? c_ST_RDY : c_ST_LOAD;
            default:   w_state_nxt = c_ST_RDY;
        endcase
    end

    always_comb begin
        w_ready_nxt = (w_state_nxt == c_ST_RDY);
        w_tx_nxt    = r_tx;
        if (r_state == c_ST_LOAD) begin
            w_tx_nxt = r_frame[r_bit_idx];
        end else if (r_state == c_ST_RDY) begin
            w_tx_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame   <= 10'h3FF;
            r_bit_idx <= '0;
            r_timer   <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
        end else begin
            r_tx    <= w_tx_nxt;
            r_ready <= w_ready_nxt;
            if (r_state == c_ST_RDY && SEND) begin
                r_frame   <= {1'b1, DATA, 1'b0};
                r_bit_idx <= '0;
            end
            if (r_state == c_ST_LOAD) begin
                r_timer <= '0;
            end else if (r_state == c_ST_SEND) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_bit_done) begin
                r_bit_idx <= r_bit_idx + 4'd1;
            end
        end
    end

    assign READY   = r_ready;
    assign UART_TX = r_tx;

    // ------------------------------------------------------------------
    // RGB colour wheel
    // ------------------------------------------------------------------
    localparam int c_STEP_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CLKS - 1);

    logic [7:0]          r_pwm_cnt;
    logic [7:0]          r_duty_r;
    logic [7:0]          r_duty_g;
    logic [7:0]          r_duty_b;
    logic [1:0]          r_phase;
    logic [c_STEP_W-1:0] r_step_cnt;
    logic [2:0]          r_led1;
    logic [2:0]          r_led2;
    logic                w_step;
    logic                w_r_on;
    logic                w_g_on;
    logic                w_b_on;

    assign w_step = (r_step_cnt == c_STEP_LAST);
    assign w_r_on = (r_pwm_cnt < r_duty_r);
    assign w_g_on = (r_pwm_cnt < r_duty_g);
    assign w_b_on = (r_pwm_cnt < r_duty_b);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm_cnt  <= '0;
            r_step_cnt <= '0;
            r_duty_r   <= 8'd255;
            r_duty_g   <= 8'd0;
            r_duty_b   <= 8'd0;
            r_phase    <= 2'd0;
            r_led1     <= '0;
            r_led2     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_led1    <= {w_r_on, w_b_on, w_g_on};
            r_led2    <= {w_g_on, w_r_on, w_b_on};
            r_step_cnt <= w_step ? '0 : r_step_cnt + 1'b1;
            // The falling channel is always >= 1 inside its phase, so the
            // phase moves on exactly when that channel lands on zero.
            if (w_step) begin
                case (r_phase)
                    2'd0: begin
                        r_duty_r <= r_duty_r - 8'd1;
                        r_duty_g <= r_duty_g + 8'd1;
                        if (r_duty_r == 8'd1) r_phase <= 2'd1;
                    end
                    2'd1: begin
                        r_duty_g <= r_duty_g - 8'd1;
                        r_duty_b <= r_duty_b + 8'd1;
                        if (r_duty_g == 8'd1) r_phase <= 2'd2;
                    end
                    2'd2: begin
                        r_duty_b <= r_duty_b - 8'd1;
                        r_duty_r <= r_duty_r + 8'd1;
                        if (r_duty_b == 8'd1) r_phase <= 2'd0;
                    end
                    default: r_phase <= 2'd0;
                endcase
            end
        end
    end

    assign RGB_LED_1_O = r_led1;
    assign RGB_LED_2_O = r_led2;

endmodule
`default_nettype wire

// File: tb/tb_gpio_io_periph.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_gpio_io_periph                                      |
// | Brief    : self-checking bench for gpio_io_periph                 |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_gpio_io_periph;

    localparam int c_DEB  = 16;
    localparam int c_BAUD = 16;
    localparam int c_STEP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig_i;
    logic [3:0] sig_o;
    logic       send;
    logic [7:0] data;
    logic       ready;
    logic       tx;
    logic [2:0] led1;
    logic [2:0] led2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gpio_io_periph #(
        .DEBNC_CLOCKS(c_DEB),
        .PORT_WIDTH  (4),
        .BAUD_CLKS   (c_BAUD),
        .STEP_CLKS   (c_STEP)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .SIGNAL_I   (sig_i),
        .SIGNAL_O   (sig_o),
        .SEND       (send),
        .DATA       (data),
        .READY      (ready),
        .UART_TX    (tx),
        .RGB_LED_1_O(led1),
        .RGB_LED_2_O(led2)
    );

    // Reference: edges since reset, raw input history (hist[k] = sample k edges ago),
    // and the expected debounced level.
    int unsigned t_edges;
    logic [3:0]  hist [1:17];
    logic [3:0]  exp_sig;

    // A level is accepted once 16 consecutive synchronised samples disagree with it.
    function automatic logic window_flips(int b);
        for (int k = 2; k <= 17; k++) begin
            if (hist[k][b] == exp_sig[b]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t_edges <= 0;
            exp_sig <= '0;
            for (int k = 1; k <= 17; k++) hist[k] <= '0;
        end else begin
            t_edges <= t_edges + 1;
            for (int b = 0; b < 4; b++) begin
                if (window_flips(b)) exp_sig[b] <= ~exp_sig[b];
            end
            hist[1] <= sig_i;
            for (int k = 2; k <= 17; k++) hist[k] <= hist[k-1];
        end
    end

    // Expected {LED1, LED2} after t edges since reset, from the wheel position.
    function automatic logic [5:0] rgb_exp(int unsigned t);
        int unsigned c, n, r, g, b;
        if (t == 0) return 6'd0;
        c = (t - 1) % 256;
        n = ((t - 1) / c_STEP) % 765;
        if (n < 255) begin
            r = 255 - n; g = n; b = 0;
        end else if (n < 510) begin
            r = 0; g = 510 - n; b = n - 255;
        end else begin
            g = 0; b = 765 - n; r = n - 510;
        end
        return {c < r, c < b, c < g, c < g, c < r, c < b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic uart_frame(input logic [7:0] d, input int inject_at);
        logic [9:0] frame;
        frame = {1'b1, d, 1'b0};
        send = 1'b1;
        data = d;
        tick();
        chk("uart_busy_after_send", 32'(ready), 32'd0);
        send = 1'b0;
        data = 8'($urandom);
        for (int c = 1; c <= 160; c++) begin
            if (c == inject_at) begin
                send = 1'b1;
                data = 8'hFF;
            end
            tick();
            send = 1'b0;
            chk("uart_tx_bit", 32'(tx), 32'(frame[(c-1)/c_BAUD]));
            chk("uart_ready_low", 32'(ready), 32'd0);
        end
        tick();
        chk("uart_ready_after_stop", 32'(ready), 32'd1);
        chk("uart_idle_line", 32'(tx), 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        sig_i = '0;
        send  = 1'b0;
        data  = '0;
        @(negedge clk);
        tick();
        tick();
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_sig_o", 32'(sig_o), 32'd0);
        chk("reset_led1", 32'(led1), 32'd0);
        chk("reset_led2", 32'(led2), 32'd0);
        rst = 1'b0;

        // Step on bit 2: accepted 16 edges after the synchronised edge.
        sig_i[2] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("deb_step_model", 32'(sig_o), 32'(exp_sig));
            if (k == 17) chk("deb_step_not_yet", 32'(sig_o), 32'd0);
            if (k == 18) chk("deb_step_rise", 32'(sig_o), 32'h4);
        end
        sig_i[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("deb_step_fall_model", 32'(sig_o), 32'(exp_sig));
        end
        chk("deb_step_fell", 32'(sig_o), 32'd0);

        // Short glitch on bit 0 is rejected.
        sig_i[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 11) sig_i[0] = 1'b0;
            tick();
            chk("deb_glitch", 32'(sig_o), 32'd0);
        end

        // Random input patterns against the window model.
        for (int e = 0; e < 30; e++) begin
            int len;
            sig_i = 4'($urandom);
            len   = $urandom_range(1, 26);
            for (int k = 0; k < len; k++) begin
                tick();
                chk("deb_random", 32'(sig_o), 32'(exp_sig));
            end
        end
        sig_i = '0;

        // UART: directed 'A', then random bytes; one frame gets a mid-frame SEND.
        uart_frame(8'h41, 0);
        uart_frame(8'($urandom), 37);
        uart_frame(8'($urandom), 0);
        uart_frame(8'($urandom), 150);

        // Reset during bit 4 aborts the frame.
        send = 1'b1;
        data = 8'($urandom);
        tick();
        send = 1'b0;
        for (int c = 1; c <= 4 * c_BAUD + 8; c++) tick();
        chk("uart_mid_ready_low", 32'(ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("uart_abort_tx", 32'(tx), 32'd1);
        chk("uart_abort_ready", 32'(ready), 32'd1);
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("uart_abort_stays_idle", 32'({ready, tx}), 32'h3);
        end

        // RGB wheel across a full revolution.
        rst = 1'b1;
        tick();
        tick();
        chk("rgb_reset", 32'({led1, led2}), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 3300; k++) begin
            tick();
            chk("rgb_model", 32'({led1, led2}), 32'(rgb_exp(t_edges)));
            if (k == 2) chk("rgb_start_red", 32'({led1, led2}), 32'({3'b100, 3'b010}));
            if (k == 1021) chk("rgb_full_green", 32'({led1, led2}), 32'({3'b001, 3'b100}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
